// File: rtl/obi_data_arbiter.sv
// Two-master to one-slave OBI data-port arbiter: round-robin issue between the core LSU
// and the vector LSU, with an in-order owner FIFO that steers each response back to its requester.
module obi_data_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          VLSU_FIRST      = 1'b0
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        core_req_i,
    output logic        core_gnt_o,
    input  logic [31:0] core_addr_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    input  logic        vlsu_req_i,
    output logic        vlsu_gnt_o,
    input  logic [31:0] vlsu_addr_i,
    input  logic        vlsu_we_i,
    input  logic [3:0]  vlsu_be_i,
    input  logic [31:0] vlsu_wdata_i,
    output logic        vlsu_rvalid_o,
    output logic [31:0] vlsu_rdata_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_VLSU = 1'b1
    } owner_e;

    owner_e             sel;
    owner_e             hold_sel_q;
    owner_e             rr_ptr_q;
    owner_e             head;
    logic               hold_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    owner_e             owner_q [MAX_OUTSTANDING];

    logic sel_req;
    logic full;
    logic empty;
    logic handshake;
    logic pop;
    logic spurious;
    logic violation;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A stalled request keeps its owner until the handshake completes.
    always_comb begin
        if (hold_q) begin
            sel = hold_sel_q;
        end else if (core_req_i && vlsu_req_i) begin
            sel = rr_ptr_q;
        end else if (vlsu_req_i) begin
            sel = OWNER_VLSU;
        end else begin
            sel = OWNER_CORE;
        end
    end

    assign sel_req   = (sel == OWNER_VLSU) ? vlsu_req_i : core_req_i;
    assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty     = (count_q == '0);
    assign mem_req_o = sel_req && !full;
    assign handshake = mem_req_o && mem_gnt_i;
    assign pop       = mem_rvalid_i && !empty;
    assign spurious  = mem_rvalid_i && empty;
    assign violation = hold_q && !sel_req;
    assign head      = owner_q[rd_ptr_q];

    assign mem_addr_o  = (sel == OWNER_VLSU) ? vlsu_addr_i  : core_addr_i;
    assign mem_we_o    = (sel == OWNER_VLSU) ? vlsu_we_i    : core_we_i;
    assign mem_be_o    = (sel == OWNER_VLSU) ? vlsu_be_i    : core_be_i;
    assign mem_wdata_o = (sel == OWNER_VLSU) ? vlsu_wdata_i : core_wdata_i;

    assign core_gnt_o = handshake && (sel == OWNER_CORE);
    assign vlsu_gnt_o = handshake && (sel == OWNER_VLSU);

    assign core_rvalid_o = pop && (head == OWNER_CORE);
    assign vlsu_rvalid_o = pop && (head == OWNER_VLSU);
    assign core_rdata_o  = mem_rdata_i;
    assign vlsu_rdata_o  = mem_rdata_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_q     <= 1'b0;
            hold_sel_q <= OWNER_CORE;
            rr_ptr_q   <= owner_e'(VLSU_FIRST);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_o      <= 1'b0;
        end else begin
            if (violation) begin
                hold_q <= 1'b0;
            end else if (mem_req_o && !mem_gnt_i) begin
                hold_q     <= 1'b1;
                hold_sel_q <= sel;
            end else if (handshake) begin
                hold_q <= 1'b0;
            end

            if (handshake) begin
                rr_ptr_q <= owner_e'(~sel);
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end

            case ({handshake, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            if (violation || spurious) begin
                err_o <= 1'b1;
            end
        end
    end

    // NOTE: owner storage needs no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (handshake) begin
            owner_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Self-checking bench for obi_data_arbiter: directed stimulus, with an owner scoreboard
// filled at each grant and drained at each memory response.
module tb_obi_data_arbiter;

    logic        clk;
    logic        n_reset;
    logic        core_req;
    logic        core_gnt;
    logic [31:0] core_addr;
    logic        core_we;
    logic [3:0]  core_be;
    logic [31:0] core_wdata;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        vlsu_req;
    logic        vlsu_gnt;
    logic [31:0] vlsu_addr;
    logic        vlsu_we;
    logic [3:0]  vlsu_be;
    logic [31:0] vlsu_wdata;
    logic        vlsu_rvalid;
    logic [31:0] vlsu_rdata;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_owner_q[$];

    obi_data_arbiter #(
        .MAX_OUTSTANDING(2),
        .VLSU_FIRST     (1'b0)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .core_req_i   (core_req),
        .core_gnt_o   (core_gnt),
        .core_addr_i  (core_addr),
        .core_we_i    (core_we),
        .core_be_i    (core_be),
        .core_wdata_i (core_wdata),
        .core_rvalid_o(core_rvalid),
        .core_rdata_o (core_rdata),
        .vlsu_req_i   (vlsu_req),
        .vlsu_gnt_o   (vlsu_gnt),
        .vlsu_addr_i  (vlsu_addr),
        .vlsu_we_i    (vlsu_we),
        .vlsu_be_i    (vlsu_be),
        .vlsu_wdata_i (vlsu_wdata),
        .vlsu_rvalid_o(vlsu_rvalid),
        .vlsu_rdata_o (vlsu_rdata),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req   = 1'b0;
        vlsu_req   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        exp_owner_q.delete();
    endtask

    // Expects mem_rvalid already driven with data; compares against the oldest recorded grant.
    task automatic check_resp(input string tag, input logic [31:0] data);
        bit owner;
        if (exp_owner_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: response with empty scoreboard", tag);
        end else begin
            owner = exp_owner_q.pop_front();
            check({tag, "_core_rvalid"}, core_rvalid, (owner == 1'b0));
            check({tag, "_vlsu_rvalid"}, vlsu_rvalid, (owner == 1'b1));
            check({tag, "_rdata"}, owner ? vlsu_rdata : core_rdata, data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        core_addr  = 32'h0000_0100;
        core_we    = 1'b0;
        core_be    = 4'hF;
        core_wdata = 32'h1111_1111;
        vlsu_addr  = 32'h0000_0300;
        vlsu_we    = 1'b1;
        vlsu_be    = 4'h3;
        vlsu_wdata = 32'h2222_2222;
        do_reset();

        // Reset state
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_core_gnt", core_gnt, 1'b0);
        check("rst_vlsu_gnt", vlsu_gnt, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rvalid", {core_rvalid, vlsu_rvalid}, 2'b00);

        // Core-only read with response one cycle after the grant
        core_req = 1'b1;
        mem_gnt  = 1'b1;
        #1;
        check("single_mem_req", mem_req, 1'b1);
        check("single_addr", mem_addr, 32'h0000_0100);
        check("single_we", mem_we, 1'b0);
        check("single_core_gnt", core_gnt, 1'b1);
        check("single_vlsu_gnt", vlsu_gnt, 1'b0);
        if (core_gnt) exp_owner_q.push_back(1'b0);
        step();
        core_req   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        check_resp("single", 32'hDEAD_BEEF);
        step();
        mem_rvalid = 1'b0;

        // Both masters requesting every cycle: strict alternation starting with the core
        do_reset();
        core_addr = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            core_req = (i < 4);
            vlsu_req = (i < 4);
            mem_gnt  = (i < 4);
            mem_rvalid = (i > 0);
            mem_rdata  = 32'h0000_1000 + i;
            #1;
            if (i > 0) check_resp($sformatf("rr%0d", i), 32'h0000_1000 + i);
            if (i < 4) begin
                check($sformatf("rr%0d_core_gnt", i), core_gnt, (i % 2) == 0);
                check($sformatf("rr%0d_vlsu_gnt", i), vlsu_gnt, (i % 2) == 1);
                check($sformatf("rr%0d_addr", i), mem_addr, (i % 2) ? 32'h0000_0300 : 32'h0000_0200);
                if (core_gnt || vlsu_gnt) exp_owner_q.push_back(vlsu_gnt);
            end
            step();
        end
        idle_inputs();

        // Stalled vlsu request holds the selection while the core joins in
        vlsu_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) core_req = 1'b1;
            #1;
            check($sformatf("hold%0d_addr", i), mem_addr, 32'h0000_0300);
            check($sformatf("hold%0d_wdata", i), mem_wdata, 32'h2222_2222);
            check($sformatf("hold%0d_mem_req", i), mem_req, 1'b1);
            step();
        end
        mem_gnt = 1'b1;
        #1;
        check("hold_vlsu_gnt", vlsu_gnt, 1'b1);
        check("hold_core_gnt", core_gnt, 1'b0);
        check("hold_final_addr", mem_addr, 32'h0000_0300);
        if (vlsu_gnt) exp_owner_q.push_back(1'b1);
        step();
        vlsu_req = 1'b0;
        #1;
        check("after_hold_core_gnt", core_gnt, 1'b1);
        check("after_hold_addr", mem_addr, 32'h0000_0200);
        if (core_gnt) exp_owner_q.push_back(1'b0);
        step();

        // Two outstanding: issue blocked until a response frees a slot
        #1;
        check("full_mem_req", mem_req, 1'b0);
        check("full_core_gnt", core_gnt, 1'b0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_00A1;
        #1;
        check_resp("full_pop1", 32'h0000_00A1);
        check("full_pop_cycle_mem_req", mem_req, 1'b0);
        step();
        mem_rdata = 32'h0000_00A2;
        #1;
        check_resp("full_pop2", 32'h0000_00A2);
        check("resume_mem_req", mem_req, 1'b1);
        check("resume_core_gnt", core_gnt, 1'b1);
        if (core_gnt) exp_owner_q.push_back(1'b0);
        step();
        core_req  = 1'b0;
        mem_gnt   = 1'b0;
        mem_rdata = 32'h0000_00A3;
        #1;
        check_resp("drain", 32'h0000_00A3);
        step();
        mem_rvalid = 1'b0;

        // Spurious response with nothing outstanding
        #1;
        check("pre_spurious_err", err, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        #1;
        check("spurious_rvalid", {core_rvalid, vlsu_rvalid}, 2'b00);
        step();
        mem_rvalid = 1'b0;
        #1;
        check("spurious_err", err, 1'b1);
        repeat (3) step();
        check("spurious_err_sticky", err, 1'b1);

        // Reset with one transaction outstanding, then a late response
        do_reset();
        #1;
        check("rst2_err", err, 1'b0);
        core_req = 1'b1;
        mem_gnt  = 1'b1;
        #1;
        check("rst2_core_gnt", core_gnt, 1'b1);
        step();
        idle_inputs();
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        exp_owner_q.delete();
        mem_rvalid = 1'b1;
        #1;
        check("late_rvalid", {core_rvalid, vlsu_rvalid}, 2'b00);
        step();
        mem_rvalid = 1'b0;
        #1;
        check("late_err", err, 1'b1);
        core_req = 1'b1;
        vlsu_req = 1'b1;
        mem_gnt  = 1'b1;
        #1;
        check("rst2_tie_core_gnt", core_gnt, 1'b1);
        check("rst2_tie_vlsu_gnt", vlsu_gnt, 1'b0);
        if (core_gnt) exp_owner_q.push_back(1'b0);
        step();
        check("rst2_second_vlsu_gnt", vlsu_gnt, 1'b1);
        if (vlsu_gnt) exp_owner_q.push_back(1'b1);
        step();
        check("rst2_full_mem_req", mem_req, 1'b0);
        core_req   = 1'b0;
        vlsu_req   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0C01;
        #1;
        check_resp("rst2_pop1", 32'h0000_0C01);
        step();
        mem_rdata = 32'h0000_0C02;
        #1;
        check_resp("rst2_pop2", 32'h0000_0C02);
        step();
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
